filtered_sample_uart_tx: RTL
============================

Name: filtered_sample_uart_tx

Overview:
Downstream consumer of the moving-average filter output.
- Accepts each 10-bit filtered sample qualified by its one-cycle strobe.
- Buffers samples in a small FIFO.
- Serialises each sample as two self-synchronising 8N1 UART bytes on a single pin, so an external host can log the filter output.
- Sits between the filter output mux and a spare uio output pin.

Parameters:
DATA_LEN, 10, sample width; legal range 8..14.
CLKS_PER_BIT, 16, clock cycles per UART bit; must be at least 2.
FIFO_DEPTH, 4, sample FIFO entries; must be a power of two, at least 2.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
data_in  input  DATA_LEN  filtered sample
strobe_in  input  1  one-cycle valid for data_in
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is in progress or the FIFO is non-empty
overflow  output  1  sticky, sample dropped because the FIFO was full
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values (while rst_n=0 at a clk edge): tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, FIFO emptied.
- Reset mid-frame aborts the frame; tx is high after the reset edge.

Push and pop:
- Push: at a clk edge with strobe_in=1, data_in is written to the FIFO tail.
- If the FIFO is full and no pop happens on the same edge, the sample is dropped and overflow is set. overflow clears only on reset.
- Push and pop on the same edge are both honoured when full; level is unchanged.
- Pop: in IDLE with the FIFO non-empty, the next edge loads the head into the sample register, pops it, and enters START for byte 0.

Byte encoding:
- byte0 = {1'b0, d[6:0]}.
- byte1 = {1'b1, zero-extended d[DATA_LEN-1:7]} (4'b0000, d[9:7] for DATA_LEN=10).
- Bit 7 marks the byte, so the host can resynchronise.

FSM and timing:
- States: IDLE, START, DATA, STOP; a byte_sel flag chooses byte0 or byte1.
- START drives tx=0; DATA sends 8 bits LSB first; STOP drives tx=1. Each bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter.
- STOP of byte0 goes directly to START of byte1, with no gap.
- STOP of byte1:
  - FIFO non-empty: pop and go to START of byte0 (back-to-back).
  - FIFO empty: go to IDLE.
- Latency: strobe_in sampled at edge E leaves the FIFO at E+1; tx falls after E+1.
- One sample occupies 20*CLKS_PER_BIT cycles on the line.
- busy = (state != IDLE) or (fifo_level != 0).

Optional Feature:
TX_PARITY_EN
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP in a PARITY state. A frame is 11 bits; a sample takes 22*CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 8N1 only, as above.

Decomposition:
Shared package contents:
- State enum (IDLE/START/DATA/STOP/PARITY).
- Byte marker constants: BYTE0_MARK=1'b0, BYTE1_MARK=1'b1.
- LOW_BITS=7.
- Bits-per-frame constants for both feature settings.

Sub-module:
- One natural sub-module, sample_fifo: parameterised synchronous FIFO with push, pop, full, empty and level outputs.
- The top holds the FSM, baud counter and shift register.

Test Plan:
1. Reset mid-frame: reset for 2 cycles, then start a frame and assert rst_n=0 mid-DATA -> tx=1 after the reset edge; fifo_level=0, overflow=0, busy=0.
2. Single sample: CLKS_PER_BIT=4, one strobe with data_in=10'h2A5 -> host decodes byte0=0x25 then byte1=0x85; tx low for exactly 4 cycles at each start bit; frame length 80 cycles; busy then 0.
3. Back-to-back drain: 3 strobes 10'h000, 10'h3FF, 10'h07F spaced 1 cycle apart -> bytes 0x00,0x80, 0x7F,0x87, 0x7F,0x80 with no idle gap; total 240 cycles at CLKS_PER_BIT=4.
4. Overflow: FIFO_DEPTH=4, 6 strobes on consecutive cycles -> first 5 transmitted in order, 6th dropped, overflow=1 and held until reset; fifo_level peaks at 4.
5. Full with simultaneous push/pop: FIFO full at the end of byte1 STOP while strobe_in=1 -> no drop, overflow stays 0, fifo_level stays 4.
6. TX_PARITY_EN defined: data_in=10'h2A5 -> byte0 0x25 with parity bit 1, byte1 0x85 with parity bit 1; sample length 88 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/filtered_sample_uart_tx_pkg.sv
// rtl/filtered_sample_uart_tx_pkg.sv - shared states, byte markers and frame constants (TX_PARITY_EN aware)
package filtered_sample_uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic BYTE0_MARK = 1'b0;
    localparam logic BYTE1_MARK = 1'b1;

    localparam int LOW_BITS     = 7;
    localparam int MAX_DATA_LEN = 14;

    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
    localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

    // Samples arrive zero-extended to MAX_DATA_LEN so one helper serves every DATA_LEN.
    function automatic logic [7:0] byte0_of(input logic [MAX_DATA_LEN-1:0] d);
        return {BYTE0_MARK, d[LOW_BITS-1:0]};
    endfunction

    function automatic logic [7:0] byte1_of(input logic [MAX_DATA_LEN-1:0] d);
        return {BYTE1_MARK, d[MAX_DATA_LEN-1:LOW_BITS]};
    endfunction

endpackage

// File: rtl/filtered_sample_uart_tx_fifo.sv
// rtl/filtered_sample_uart_tx_fifo.sv - synchronous sample FIFO with full/empty/level
module sample_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/filtered_sample_uart_tx.sv
// rtl/filtered_sample_uart_tx.sv - FIFO-buffered two-byte UART logger of filtered samples; TX_PARITY_EN adds even parity
module filtered_sample_uart_tx
    import filtered_sample_uart_tx_pkg::*;
#(
    parameter int DATA_LEN     = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_LEN-1:0]         data_in,
    input  logic                        strobe_in,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [2:0]          state_q, state_d;
    logic [BW-1:0]       baud_q, baud_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic                byte_sel_q, byte_sel_d;
    logic [DATA_LEN-1:0] sample_q, sample_d;
    logic [7:0]          shift_q, shift_d;
    logic                overflow_q, overflow_d;

    logic                fifo_pop, fifo_full, fifo_empty;
    logic [DATA_LEN-1:0] fifo_rdata;
    logic                baud_end;

    sample_fifo #(
        .WIDTH (DATA_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (strobe_in),
        .wdata_i (data_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

`ifdef TX_PARITY_EN
    logic parity_bit;
    assign parity_bit = byte_sel_q ? ^byte1_of(MAX_DATA_LEN'(sample_q))
                                   : ^byte0_of(MAX_DATA_LEN'(sample_q));
`endif

    always_comb begin
        state_d    = state_q;
        baud_d     = (state_q == ST_IDLE || baud_end) ? '0 : baud_q + BW'(1);
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        sample_d   = sample_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    sample_d   = fifo_rdata;
                    shift_d    = byte0_of(MAX_DATA_LEN'(fifo_rdata));
                    byte_sel_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        shift_d    = byte1_of(MAX_DATA_LEN'(sample_q));
                        state_d    = ST_START;
                    end else if (!fifo_empty) begin
                        // Back-to-back: the next sample starts with no idle bit.
                        fifo_pop   = 1'b1;
                        sample_d   = fifo_rdata;
                        shift_d    = byte0_of(MAX_DATA_LEN'(fifo_rdata));
                        byte_sel_d = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign overflow_d = overflow_q | (strobe_in && fifo_full && !fifo_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_sel_q <= 1'b0;
            sample_q   <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            sample_q   <= sample_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
`ifdef TX_PARITY_EN
            ST_PARITY: tx = parity_bit;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign busy     = (state_q != ST_IDLE) || (fifo_level != '0);
    assign overflow = overflow_q;

endmodule
